// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake, iterative rotates and status flags.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier on opcode 10.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_ROLV = 4'd6;
  localparam logic [3:0] OP_RORV = 4'd7;
  localparam logic [3:0] OP_BLEU = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] res_c, step_res;
  logic             cy_c, ov_c, il_c, is_rot;
  logic [SHW-1:0]   amt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign O         = o_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  assign amt    = I2[SHW-1:0];
  assign is_rot = (op == OP_ROLV) || (op == OP_RORV);

  // Single-cycle result and flags straight from the presented operands
  always_comb begin
    add_s = {1'b0, I1} + {1'b0, I2};
    sub_s = {1'b0, I1} - {1'b0, I2};
    res_c = '0;
    cy_c  = 1'b0;
    ov_c  = 1'b0;
    il_c  = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = add_s[WIDTH-1:0];
        cy_c  = add_s[WIDTH];
        ov_c  = (I1[WIDTH-1] == I2[WIDTH-1]) && (add_s[WIDTH-1] != I1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = sub_s[WIDTH-1:0];
        cy_c  = ~sub_s[WIDTH];
        ov_c  = (I1[WIDTH-1] != I2[WIDTH-1]) && (sub_s[WIDTH-1] != I1[WIDTH-1]);
      end
      OP_NOR:           res_c = ~(I1 | I2);
      OP_NOT:           res_c = ~I1;
      OP_AND:           res_c = I1 & I2;
      OP_OR:            res_c = I1 | I2;
      OP_ROLV, OP_RORV: res_c = I1;
      OP_BLEU:          res_c = WIDTH'(I1 <= I2);
      OP_PASS:          res_c = I1;
      default:          il_c  = 1'b1;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    step_res = '0;
`ifdef SEQ_ALU_MUL_EN
    b_d      = b_q;
    acc_d    = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          a_d  = I1;
          if (is_rot && (amt != '0)) begin
            state_d = RUN;
            cnt_d   = CW'(amt);
          end
`ifdef SEQ_ALU_MUL_EN
          else if (op == OP_MUL) begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
            b_d     = I2;
            acc_d   = '0;
          end
`endif
          else begin
            state_d = DONE;
            o_d     = res_c;
            zero_d  = (res_c == '0);
            carry_d = cy_c;
            ovf_d   = ov_c;
            err_d   = il_c;
          end
        end
      end
      RUN: begin
        cnt_d    = cnt_q - CW'(1);
        step_res = (op_q == OP_ROLV) ? {a_q[WIDTH-2:0], a_q[WIDTH-1]}
                                     : {a_q[0], a_q[WIDTH-1:1]};
        a_d      = step_res;
`ifdef SEQ_ALU_MUL_EN
        // One multiplier bit per cycle: add shifted multiplicand when the LSB is set
        if (op_q == OP_MUL) begin
          step_res = acc_q + (b_q[0] ? a_q : '0);
          acc_d    = step_res;
          a_d      = a_q << 1;
          b_d      = b_q >> 1;
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          o_d     = step_res;
          zero_d  = (step_res == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      b_q     <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef SEQ_ALU_MUL_EN
      b_q     <= b_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: scoreboard of reference results, latency, back-pressure and reset abort.
module tb_seq_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] I1;
  logic [W-1:0] I2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] O;
  logic         zero;
  logic         carry;
  logic         ovf;
  logic         err;

  typedef struct packed {
    logic [W-1:0] o;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .I1        (I1),
    .I2        (I2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (O),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: wide arithmetic and double-width rotates
  function automatic exp_t model(input logic [3:0] o_op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] t;
    longint      r;
    logic [4:0]  amt;
    e   = '0;
    e.lat = 8'd1;
    amt = b[4:0];
    case (o_op)
      4'd0: begin
        t = {32'b0, a} + {32'b0, b};
        e.o = t[31:0];
        e.carry = t[32];
        r = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        e.o = a - b;
        e.carry = (a >= b);
        r = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2: e.o = ~(a | b);
      4'd3: e.o = ~a;
      4'd4: e.o = a & b;
      4'd5: e.o = a | b;
      4'd6: begin
        t = {a, a} << amt;
        e.o = t[63:32];
        e.lat = 8'(amt) + 8'd1;
      end
      4'd7: begin
        t = {a, a} >> amt;
        e.o = t[31:0];
        e.lat = 8'(amt) + 8'd1;
      end
      4'd8: e.o = (a <= b) ? 32'd1 : 32'd0;
      4'd9: e.o = a;
`ifdef SEQ_ALU_MUL_EN
      4'd10: begin
        t = {32'b0, a} * {32'b0, b};
        e.o = t[31:0];
        e.lat = 8'd33;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.o == '0);
    return e;
  endfunction

  task automatic run_op(input logic [3:0] o_op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    exp_t         e;
    int           cyc;
    logic [W-1:0] o_held;
    sb_q.push_back(model(o_op, a, b));
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o_op;
    I1 = a;
    I2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    I1 = $urandom;
    I2 = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    e = sb_q.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("O", 64'(O), 64'(e.o));
    chk("zero", 64'(zero), 64'(e.zero));
    chk("carry", 64'(carry), 64'(e.carry));
    chk("ovf", 64'(ovf), 64'(e.ovf));
    chk("err", 64'(err), 64'(e.err));
    chk("busy_ready", 64'(in_ready), 64'd0);
    o_held = O;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      op = 4'($urandom);
      I1 = $urandom;
      @(posedge clk);
      #1;
      chk("hold_O", 64'(O), 64'(o_held));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic abort_op(input logic [3:0] o_op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int after);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o_op;
    I1 = a;
    I2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (after) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_O", 64'(O), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    I1 = '0;
    I2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_O", 64'(O), 64'd0);
    chk("rst_flags", 64'({zero, carry, ovf, err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'd1, 32'd5, 32'd5, 0);
    run_op(4'd6, 32'h8000_0001, 32'd4, 0);
    run_op(4'd7, 32'h1234_5678, 32'd0, 0);
    run_op(4'd7, 32'h1234_5678, 32'h20, 0);
    run_op(4'd7, 32'h1234_5678, 32'hFFFF_FF25, 1);
    run_op(4'd6, 32'hDEAD_BEEF, 32'd31, 0);
    run_op(4'd8, 32'd3, 32'd3, 0);
    run_op(4'd8, 32'd4, 32'd3, 0);
    run_op(4'd13, 32'h1234, 32'h5678, 0);
    run_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 0);
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd1, 32'd3, 32'd5, 0);
    run_op(4'd1, 32'h8000_0000, 32'd1, 0);
    run_op(4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op(4'd3, 32'h0F0F_0F0F, 32'd0, 0);
    run_op(4'd9, 32'hCAFE_F00D, 32'd7, 0);
    run_op(4'd5, 32'hA5A5_0000, 32'h0000_5A5A, 10);

    for (int k = 0; k < 24; k++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    abort_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 5);
    abort_op(4'd6, 32'h0000_0001, 32'd20, 3);
    run_op(4'd0, 32'd1, 32'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
